// File: rtl/pl_pkg.sv
// pl_pkg: shared pipeline encodings, NOP constant and IF-stage state type.
package pl_pkg;
    localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
    localparam logic [1:0]  PCSRC_BRA  = 2'b01;
    localparam logic [1:0]  PCSRC_JALR = 2'b10;
    localparam logic [1:0]  PCSRC_JAL  = 2'b11;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} if_state_e;
endpackage

// File: rtl/pl_if_next_pc.sv
// pl_if_next_pc: redirect target mux and sequential fetch-address adder, both word aligned.
// Ports: pcsrc_i (ID next-PC select), bra_i/jalra_i/jala_i (candidate targets),
//        fa_i (current fetch address), target_o (aligned redirect target), fa_inc_o (fa_i+4).
module pl_if_next_pc import pl_pkg::*; (
    input  logic [1:0]  pcsrc_i,
    input  logic [31:0] bra_i,
    input  logic [31:0] jalra_i,
    input  logic [31:0] jala_i,
    input  logic [31:0] fa_i,
    output logic [31:0] target_o,
    output logic [31:0] fa_inc_o
);
    logic [31:0] raw;
    always_comb begin
        raw      = (pcsrc_i == PCSRC_BRA) ? bra_i : (pcsrc_i == PCSRC_JALR) ? jalra_i : jala_i;
        target_o = raw & ~32'h3;
        fa_inc_o = (fa_i + 32'd4) & ~32'h3;
    end
endmodule

// File: rtl/pl_stage_if.sv
// pl_stage_if: instruction-fetch stage owning the PC, the imem handshake and the IF/ID register.
// Ports: clk, rst (sync, active-high); pcsrc/bra/jalra/jala/wpcir from ID;
//        imem_req/imem_addr out and imem_ack/imem_rdata in for instruction memory;
//        dpc/inst/d_valid IF/ID register outputs.
// Optional: define PL_STAGE_IF_PERF_EN to add fetch_cnt, squash_cnt and stall_cnt outputs.
module pl_stage_if import pl_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pl_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bra,
    input  logic [31:0] jalra,
    input  logic [31:0] jala,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc,
    output logic [31:0] inst,
`ifdef PL_STAGE_IF_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        d_valid
);
    if_state_e   state_q, state_d;
    logic [31:0] fa_q, fa_d, tgt_q, tgt_d, hbuf_q, hbuf_d, hpc_q, hpc_d;
    logic [31:0] inst_q, inst_d, dpc_q, dpc_d;
    logic        dv_q, dv_d;
    logic [31:0] target, fa_inc;
    logic        adv, redirect;

    pl_if_next_pc u_next_pc (
        .pcsrc_i  (pcsrc),
        .bra_i    (bra),
        .jalra_i  (jalra),
        .jala_i   (jala),
        .fa_i     (fa_q),
        .target_o (target),
        .fa_inc_o (fa_inc)
    );

    assign adv       = ~dv_q | wpcir;
    assign redirect  = dv_q & wpcir & (pcsrc != PCSRC_SEQ);
    // The request drops combinationally in the reset cycle so the memory never sees a stale address.
    assign imem_req  = ~rst & (state_q != HOLD);
    assign imem_addr = fa_q;
    assign dpc       = dpc_q;
    assign inst      = inst_q;
    assign d_valid   = dv_q;

    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        tgt_d   = tgt_q;
        hbuf_d  = hbuf_q;
        hpc_d   = hpc_q;
        inst_d  = inst_q;
        dpc_d   = dpc_q;
        dv_d    = dv_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    dv_d   = 1'b0;
                    inst_d = NOP_INST;
                    if (imem_ack) fa_d = target;
                    else begin
                        // The in-flight request must complete before the new address may be issued.
                        tgt_d   = target;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    fa_d = fa_inc;
                    if (adv) begin
                        inst_d = imem_rdata;
                        dpc_d  = fa_q;
                        dv_d   = 1'b1;
                    end else begin
                        hbuf_d  = imem_rdata;
                        hpc_d   = fa_q;
                        state_d = HOLD;
                    end
                end else if (adv) begin
                    dv_d   = 1'b0;
                    inst_d = NOP_INST;
                end
            end
            HOLD: begin
                if (redirect) begin
                    dv_d    = 1'b0;
                    inst_d  = NOP_INST;
                    fa_d    = target;
                    state_d = FETCH;
                end else if (adv) begin
                    inst_d  = hbuf_q;
                    dpc_d   = hpc_q;
                    dv_d    = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    fa_d    = tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            fa_q    <= RESET_PC;
            tgt_q   <= '0;
            hbuf_q  <= '0;
            hpc_q   <= '0;
            inst_q  <= NOP_INST;
            dpc_q   <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            tgt_q   <= tgt_d;
            hbuf_q  <= hbuf_d;
            hpc_q   <= hpc_d;
            inst_q  <= inst_d;
            dpc_q   <= dpc_d;
            dv_q    <= dv_d;
        end
    end

`ifdef PL_STAGE_IF_PERF_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q, stall_cnt_q;
    logic        fetch_inc, squash_inc;
    assign fetch_inc  = ~redirect & adv & ((state_q == FETCH & imem_ack) | state_q == HOLD);
    assign squash_inc = (state_q == FETCH & redirect & imem_ack) | (state_q == HOLD & redirect) |
                        (state_q == DRAIN & imem_ack);
    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {31'd0, fetch_inc};
            squash_cnt_q <= squash_cnt_q + {31'd0, squash_inc};
            stall_cnt_q  <= stall_cnt_q + {31'd0, dv_q & ~wpcir};
        end
    end
`endif
endmodule

// File: tb/tb_pl_stage_if.sv
// tb_pl_stage_if: table-driven directed bench for the IF stage with a variable-latency imem model.
module tb_pl_stage_if;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEE0;

    logic        clk = 1'b0;
    logic        rst, wpcir, imem_req, imem_ack, d_valid;
    logic [1:0]  pcsrc;
    logic [31:0] bra, jalra, jala, imem_addr, imem_rdata, dpc, inst;
`ifdef PL_STAGE_IF_PERF_EN
    logic [31:0] fetch_cnt, squash_cnt, stall_cnt;
`endif
    int lat, wcnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pl_stage_if dut (
        .clk        (clk),
        .rst        (rst),
        .pcsrc      (pcsrc),
        .bra        (bra),
        .jalra      (jalra),
        .jala       (jala),
        .wpcir      (wpcir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dpc        (dpc),
        .inst       (inst),
`ifdef PL_STAGE_IF_PERF_EN
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .d_valid    (d_valid)
    );

    // Memory: data is the inverted address; ack after lat wait cycles of a held request.
    assign imem_rdata = ~imem_addr;
    assign imem_ack   = imem_req && (wcnt >= lat);
    always @(posedge clk) wcnt <= (rst || !imem_req || imem_ack) ? 0 : wcnt + 1;

    typedef struct {
        logic        rst;
        logic        w;
        logic [1:0]  ps;
        logic [31:0] tgt;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] dpc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic w, logic [1:0] ps, logic [31:0] tgt, int l,
                                logic req, logic [31:0] addr, logic dv, logic [31:0] pc);
        vec_t v;
        v.rst = r; v.w = w; v.ps = ps; v.tgt = tgt; v.lat = l;
        v.req = req; v.addr = addr; v.dv = dv; v.dpc = pc;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Selected target gets tgt, the others get junk so a wrong mux leg is visible.
    task automatic apply(int idx, vec_t v);
        rst   = v.rst;
        wpcir = v.w;
        pcsrc = v.ps;
        bra   = (v.ps == 2'b01) ? v.tgt : JUNK;
        jalra = (v.ps == 2'b10) ? v.tgt : JUNK;
        jala  = (v.ps == 2'b11) ? v.tgt : JUNK;
        lat   = v.lat;
        if (v.rst) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("imem_req", idx, {31'd0, imem_req}, {31'd0, v.req});
        if (v.req) chk("imem_addr", idx, imem_addr, v.addr);
        chk("d_valid", idx, {31'd0, d_valid}, {31'd0, v.dv});
        if (v.dv || v.rst) chk("dpc", idx, dpc, v.dpc);
        chk("inst", idx, inst, v.dv ? ~v.dpc : NOP);
        @(posedge clk);
        #1;
    endtask

    int sa, sc, sd, se, sf;

    initial begin
        rst = 1'b1; wpcir = 1'b1; pcsrc = 2'b00; bra = '0; jalra = '0; jala = '0; lat = 0;
        sa = vq.size();
        vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h04, 1, 32'h00));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h08, 1, 32'h04));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h0C, 1, 32'h08));
        vq.push_back(mk(0, 0, 2'b00, 0, 0, 1, 32'h10, 1, 32'h0C));
        vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 32'h14, 1, 32'h0C));
        vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 32'h14, 1, 32'h0C));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 32'h14, 1, 32'h0C));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h14, 1, 32'h10));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h18, 1, 32'h14));
        sc = vq.size();
        vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h04, 1, 32'h00));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h08, 1, 32'h04));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h0C, 1, 32'h08));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h10, 1, 32'h0C));
        vq.push_back(mk(0, 1, 2'b01, 32'h41, 0, 1, 32'h14, 1, 32'h10));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h40, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h44, 1, 32'h40));
        sd = vq.size();
        vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h04, 1, 32'h00));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h08, 1, 32'h04));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h0C, 1, 32'h08));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h10, 1, 32'h0C));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h14, 1, 32'h10));
        vq.push_back(mk(0, 1, 2'b11, 32'h100, 2, 1, 32'h18, 1, 32'h14));
        vq.push_back(mk(0, 1, 2'b00, 0, 2, 1, 32'h18, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 2, 1, 32'h18, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h100, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h104, 1, 32'h100));
        se = vq.size();
        vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h04, 1, 32'h00));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h08, 1, 32'h04));
        vq.push_back(mk(0, 0, 2'b10, 32'h200, 0, 1, 32'h0C, 1, 32'h08));
        vq.push_back(mk(0, 0, 2'b10, 32'h200, 0, 0, 32'h10, 1, 32'h08));
        vq.push_back(mk(0, 1, 2'b10, 32'h200, 0, 0, 32'h10, 1, 32'h08));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h200, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h204, 1, 32'h200));
        sf = vq.size();
        vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 2'b11, 32'hFFFF_FFFF, 0, 1, 32'h04, 1, 32'h00));
        vq.push_back(mk(0, 1, 2'b01, 32'h80, 0, 1, 32'hFFFF_FFFC, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h00, 1, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 32'h04, 1, 32'h00));

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

        // Reset while parked in HOLD: request drops at once, fetch restarts at RESET_PC.
        rst = 1'b1; wpcir = 1'b1; pcsrc = 2'b00; lat = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wpcir = 1'b0;
        @(negedge clk);
        chk("hold_dpc", 100, dpc, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_req", 101, {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req", 102, {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wpcir = 1'b1;
        @(negedge clk);
        chk("rel_req", 103, {31'd0, imem_req}, 32'd1);
        chk("rel_addr", 103, imem_addr, 32'h0);
        chk("rel_dv", 103, {31'd0, d_valid}, 32'd0);
        chk("rel_inst", 103, inst, NOP);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_dpc", 104, dpc, 32'h0);
        chk("rel_addr2", 104, imem_addr, 32'h4);

`ifdef PL_STAGE_IF_PERF_EN
        for (int i = sa; i < sc; i++) apply(i, vq[i]);
        chk("stall_cnt", 200, stall_cnt, 32'd3);
        chk("fetch_cnt", 200, fetch_cnt, 32'd7);
        chk("squash_cnt", 200, squash_cnt, 32'd0);
        for (int i = sc; i < sd; i++) apply(i, vq[i]);
        chk("fetch_cnt", 201, fetch_cnt, 32'd7);
        chk("squash_cnt", 201, squash_cnt, 32'd1);
        chk("stall_cnt", 201, stall_cnt, 32'd0);
`endif
        if (sd + se + sf < 0) failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
